// File: rtl/top_key_arb.sv
// Multi-channel key ingress: per-channel FIFOs merged by a round-robin arbiter into one registered, channel-tagged stream.
// Optional build macro TOP_KEY_ARB_PRIO_EN gives channel 0 strict priority over the round-robin channels.
module top_key_arb #(
    parameter  int chan_p  = 2,
    parameter  int width_p = 9,
    parameter  int depth_p = 4,
    localparam int chan_w  = (chan_p > 1) ? $clog2(chan_p) : 1
) (
    input  logic                            main_clk_i,
    input  logic                            main_rst_an_i,
    input  logic [chan_p-1:0]               key_valid_i,
    output logic [chan_p-1:0]               key_accept_o,
    input  logic [chan_p-1:0][width_p-1:0]  key_data_i,
    output logic                            out_valid_o,
    input  logic                            out_accept_i,
    output logic [width_p-1:0]              out_data_o,
    output logic [chan_w-1:0]               out_chan_o,
    output logic                            busy_o
);

    localparam int                 ptr_w      = $clog2(depth_p);
    localparam int                 cnt_w      = ptr_w + 1;
    localparam int unsigned        nchan_c    = chan_p;
    localparam logic [cnt_w-1:0]   full_c     = cnt_w'(depth_p);
    localparam logic [chan_w-1:0]  last_rst_c = chan_w'(chan_p - 1);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t               state_q, state_d;
    logic [width_p-1:0]   mem_q    [chan_p][depth_p];
    logic [ptr_w-1:0]     rd_ptr_q [chan_p];
    logic [ptr_w-1:0]     wr_ptr_q [chan_p];
    logic [cnt_w-1:0]     count_q  [chan_p];
    logic [chan_p-1:0]    push, pop, nonempty;
    logic [chan_w-1:0]    last_q, last_d, win;
    logic                 found, load;
    logic [width_p-1:0]   data_q;
    logic [chan_w-1:0]    chan_q;

    always_comb begin
        key_accept_o = '0;
        push         = '0;
        nonempty     = '0;
        for (int unsigned c = 0; c < nchan_c; c++) begin
            key_accept_o[c] = (count_q[c] != full_c);
            push[c]         = key_valid_i[c] && (count_q[c] != full_c);
            nonempty[c]     = (count_q[c] != '0);
        end
    end

    always_comb begin
        int unsigned       idx;
        logic [chan_w-1:0] cand;
        load    = (state_q == EMPTY) || out_accept_i;
        found   = 1'b0;
        win     = last_q;
        last_d  = last_q;
        pop     = '0;
        state_d = state_q;
        idx     = 0;
        cand    = '0;
`ifdef TOP_KEY_ARB_PRIO_EN
        if (nonempty[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
        for (int unsigned i = 1; i <= nchan_c; i++) begin
            idx = 32'(last_q) + i;
            if (idx >= nchan_c) idx = idx - nchan_c;
            cand = chan_w'(idx);
`ifdef TOP_KEY_ARB_PRIO_EN
            if (!found && nonempty[cand] && (idx != 0)) begin
`else
            if (!found && nonempty[cand]) begin
`endif
                found = 1'b1;
                win   = cand;
            end
        end
        if (load) begin
            state_d = found ? HOLD : EMPTY;
            if (found) begin
`ifdef TOP_KEY_ARB_PRIO_EN
                // channel 0 grants must not disturb the rotation of the others
                if (win != '0) last_d = win;
`else
                last_d = win;
`endif
                for (int unsigned c = 0; c < nchan_c; c++) begin
                    pop[c] = (win == chan_w'(c));
                end
            end
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q <= EMPTY;
            last_q  <= last_rst_c;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            for (int unsigned c = 0; c < nchan_c; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < nchan_c; c++) begin
                if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
                if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                case ({push[c], pop[c]})
                    2'b10:   count_q[c] <= count_q[c] + 1'b1;
                    2'b01:   count_q[c] <= count_q[c] - 1'b1;
                    default: count_q[c] <= count_q[c];
                endcase
            end
        end
    end

    always_ff @(posedge main_clk_i) begin
        for (int unsigned c = 0; c < nchan_c; c++) begin
            if (push[c]) mem_q[c][wr_ptr_q[c]] <= key_data_i[c];
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            data_q <= '0;
            chan_q <= '0;
        end else if (load && found) begin
            data_q <= mem_q[win][rd_ptr_q[win]];
            chan_q <= win;
        end
    end

    assign out_valid_o = (state_q == HOLD);
    assign out_data_o  = data_q;
    assign out_chan_o  = chan_q;
    assign busy_o      = (|nonempty) || (state_q == HOLD);

endmodule

// File: tb/tb_top_key_arb.sv
// Bench for top_key_arb: queue-based reference model checked every cycle, plus directed literal checks.
module tb_top_key_arb;

    localparam int CH = 2;
    localparam int W  = 9;
    localparam int D  = 4;

    logic                  clk, rst_n;
    logic [CH-1:0]         kv, ka;
    logic [CH-1:0][W-1:0]  kd;
    logic                  ov, oa, busy;
    logic [W-1:0]          od;
    logic [0:0]            oc;

    int total = 0;
    int bad   = 0;

    top_key_arb #(.chan_p(CH), .width_p(W), .depth_p(D)) dut (
        .main_clk_i    (clk),
        .main_rst_an_i (rst_n),
        .key_valid_i   (kv),
        .key_accept_o  (ka),
        .key_data_i    (kd),
        .out_valid_o   (ov),
        .out_accept_i  (oa),
        .out_data_o    (od),
        .out_chan_o    (oc),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel holding FIFO contents, plus the output word.
    logic [W-1:0] mq [CH][$];
    logic         mv;
    logic [W-1:0] md;
    int           mc, mlast, mwin;
    bit           mfound, mload;
    logic [CH-1:0] mpush, acc_seen;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) mq[c].delete();
            mv = 1'b0; md = '0; mc = 0; mlast = CH - 1; acc_seen = '0;
            chk("rst_valid", ov, 0);
            chk("rst_data", od, 0);
            chk("rst_chan", oc, 0);
            chk("rst_busy", busy, 0);
            chk("rst_accept", ka, 2'b11);
        end else begin
            chk("m_valid", ov, mv);
            if (mv) begin
                chk("m_data", od, md);
                chk("m_chan", oc, mc);
            end
            for (int c = 0; c < CH; c++) begin
                chk("m_accept", ka[c], (mq[c].size() < D));
                mpush[c] = kv[c] && (mq[c].size() < D);
            end
            chk("m_busy", busy, (mv || mq[0].size() > 0 || mq[1].size() > 0));
            acc_seen = kv & ka;
            mload  = !mv || oa;
            mfound = 0;
            mwin   = 0;
            if (mload) begin
`ifdef TOP_KEY_ARB_PRIO_EN
                if (mq[0].size() > 0) begin mfound = 1; mwin = 0; end
`endif
                for (int k = 1; k <= CH; k++) begin
                    int c;
                    c = (mlast + k) % CH;
`ifdef TOP_KEY_ARB_PRIO_EN
                    if (!mfound && c != 0 && mq[c].size() > 0) begin mfound = 1; mwin = c; end
`else
                    if (!mfound && mq[c].size() > 0) begin mfound = 1; mwin = c; end
`endif
                end
                if (mfound) begin
                    md = mq[mwin].pop_front();
                    mc = mwin;
                    mv = 1'b1;
`ifdef TOP_KEY_ARB_PRIO_EN
                    if (mwin != 0) mlast = mwin;
`else
                    mlast = mwin;
`endif
                end else begin
                    mv = 1'b0;
                end
            end
            for (int c = 0; c < CH; c++) if (mpush[c]) mq[c].push_back(kd[c]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [W-1:0] d);
        bit ok;
        int n;
        kv[c] = 1'b1;
        kd[c] = d;
        n = 0;
        do begin
            @(negedge clk);
            ok = ka[c];
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; kv = '0; kd = '0; oa = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // idle after reset
        @(negedge clk);
        chk("idle_accept", ka, 2'b11);
        chk("idle_valid", ov, 0);
        chk("idle_busy", busy, 0);

        // single word on channel 1: one cycle after it lands in the FIFO it is on the output
        tick();
        oa = 1'b1;
        push(1, 9'h1A5);
        kv = '0;
        tick();
        @(negedge clk);
        chk("single_valid", ov, 1);
        chk("single_data", od, 9'h1A5);
        chk("single_chan", oc, 1);

        // full and pointer wrap on channel 0
        tick(); tick();
        oa = 1'b0;
        for (int i = 1; i <= 5; i++) push(0, W'(i));
        kv = '0;
        @(negedge clk);
        chk("full_accept0", ka[0], 0);
        chk("full_accept1", ka[1], 1);
        tick();
        oa = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("wrap_valid", ov, 1);
            chk("wrap_data", od, W'(i));
        end
        tick(); tick();

        // fairness with both channels continuously valid
        do_reset();
        oa = 1'b1;
        kv = 2'b11;
        kd[0] = 9'h00A;
        kd[1] = 9'h00B;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fair_valid", ov, 1);
`ifdef TOP_KEY_ARB_PRIO_EN
            chk("fair_chan", oc, 0);
            chk("fair_data", od, 9'h00A);
`else
            chk("fair_chan", oc, i % 2);
            chk("fair_data", od, (i % 2 == 0) ? 9'h00A : 9'h00B);
`endif
        end
        tick();
        kv = '0;
        repeat (12) tick();

        // stall stability
        do_reset();
        oa = 1'b0;
        push(1, 9'h011);
        push(1, 9'h022);
        push(1, 9'h033);
        kv = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", ov, 1);
            chk("stall_data", od, 9'h011);
            chk("stall_chan", oc, 1);
        end
        chk("stall_busy", busy, 1);

        // asynchronous reset mid-operation
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("areset_valid", ov, 0);
        chk("areset_data", od, 0);
        chk("areset_chan", oc, 0);
        chk("areset_busy", busy, 0);
        chk("areset_accept", ka, 2'b11);
        tick();
        rst_n = 1'b1;
        oa = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_valid", ov, 0);
        end
        tick();

        // randomized traffic, checked by the model each cycle
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (!kv[c] || acc_seen[c]) begin
                    kv[c] = ($urandom_range(0, 3) != 0);
                    kd[c] = W'($urandom);
                end
            end
            if (n < 1500) oa = ($urandom_range(0, 3) != 0);
            else          oa = ($urandom_range(0, 3) == 0);
            tick();
        end
        kv = '0;
        oa = 1'b1;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/top_key_arb.md
# top_key_arb

Parametrised multi-channel successor to the single key_i valid/accept ingress of the top core. It buffers `chan_p` independent key streams in per-channel FIFOs and merges them into one registered output stream. Channels are served by a fair round-robin arbiter, and each output word is tagged with its source channel. It sits between the key sources and the top-level key consumer in the main clock domain.

## Interface
Parameters:
- `chan_p`, default 2: number of input channels, 1..16.
- `width_p`, default 9: key data width.
- `depth_p`, default 4: FIFO entries per channel; must be a power of two and at least 2.
- Derived localparam `chan_w = (chan_p > 1) ? $clog2(chan_p) : 1`.

Ports (reset is asynchronous and active-low; one clock):
- `main_clk_i`  in  1  Clock.
- `main_rst_an_i`  in  1  Async reset, low-active.
- `key_valid_i`  in  `[chan_p-1:0]`  Per-channel valid.
- `key_accept_o`  out  `[chan_p-1:0]`  Per-channel accept.
- `key_data_i`  in  `[chan_p-1:0][width_p-1:0]`  Per-channel data.
- `out_valid_o`  out  1  Merged stream valid.
- `out_accept_i`  in  1  Merged stream accept.
- `out_data_o`  out  `[width_p-1:0]`  Merged data.
- `out_chan_o`  out  `[chan_w-1:0]`  Source channel of `out_data_o`.
- `busy_o`  out  1  High if any FIFO is non-empty or `out_valid_o` is high.

## Operation
- Transfer rule, both sides: a transfer occurs in a cycle where valid and accept are both high.
- Senders hold valid and data stable until accepted.
- Per-channel FIFO:
  - Read pointer, write pointer and count registers; pointers are `$clog2(depth_p)` bits and wrap naturally.
  - Count is `$clog2(depth_p)+1` bits.
- `key_accept_o[c]` is combinational: `!(count[c] == depth_p)`. There is no full-bypass, so a full FIFO refuses input even if it is popped in the same cycle.
- Simultaneous push and pop on the same FIFO leaves count unchanged; both pointers advance.
- Output register states:
  - EMPTY: `out_valid_o` = 0.
  - HOLD: `out_valid_o` = 1.
- Load condition: the arbiter may load when in EMPTY, or when in HOLD and `out_accept_i` = 1.
- Arbitration, when the load condition holds:
  - Candidates are the non-empty FIFOs.
  - Scan starts at `last_q + 1` (modulo `chan_p`); the first candidate wins.
  - The winner is popped and its head word and channel index are registered into `out_data_o` / `out_chan_o`; `last_q` takes the winner index.
- Transitions:
  - Load with a winner: go to or stay in HOLD.
  - Load with no winner: go to or stay in EMPTY.
- While in HOLD with `out_accept_i` = 0:
  - `out_data_o` and `out_chan_o` are frozen.
  - No FIFO is popped.
  - `last_q` is unchanged.
- Data present on `key_data_i` is never forwarded combinationally to the output; it always passes through its FIFO.
- `chan_p` = 1: the arbiter degenerates to a single FIFO and `out_chan_o` = 0.

## Timing
- Reset values:
  - `out_valid_o` = 0, `out_data_o` = 0, `out_chan_o` = 0, `busy_o` = 0.
  - `key_accept_o` = all ones, because all counts reset to 0.
  - All pointers = 0; `last_q` = `chan_p-1`, so channel 0 has first priority.
- Latency: a word accepted into an empty FIFO in cycle N, with the output EMPTY, appears at `out_valid_o` in cycle N+1.
- Throughput: one output word per cycle while `out_accept_i` is held high and any FIFO is non-empty.
- Reset asserted mid-operation:
  - All FIFO contents and the output register are discarded immediately (async).
  - Outputs take their reset values; no partial word survives.
- Deassertion of `main_rst_an_i` must be synchronised externally to `main_clk_i`.

## Configuration
Macro: `TOP_KEY_ARB_PRIO_EN`.
- Defined: channel 0 has strict priority. If FIFO 0 is non-empty at a load it always wins; the remaining channels are round-robin among themselves using `last_q`, which is updated only by grants to channels 1..`chan_p-1`.
- Not defined: pure round-robin over all channels as described above.
- The interface is identical in both builds.

## Test plan
- Reset then idle: after reset, `key_accept_o` = 2'b11, `out_valid_o` = 0, `busy_o` = 0.
- Single word, `chan_p` = 2, `width_p` = 9: push 9'h1A5 on channel 1 in cycle N with `out_accept_i` = 1 → `out_valid_o` = 1, `out_data_o` = 9'h1A5, `out_chan_o` = 1 in cycle N+1.
- Full and wrap, `depth_p` = 4, `out_accept_i` = 0:
  - Push 1, 2, 3, 4, 5 on channel 0 → first word moves to the output register, FIFO then fills.
  - `key_accept_o[0]` drops after 5 accepted words.
  - Raise `out_accept_i` → output sequence 1, 2, 3, 4, 5, proving pointer wrap.
- Fairness: both channels continuously valid with data 0xA / 0xB, `out_accept_i` = 1 → `out_chan_o` alternates 0, 1, 0, 1 starting at 0 (default build). With `TOP_KEY_ARB_PRIO_EN` defined → `out_chan_o` stays 0 while channel 0 has data.
- Stall stability: hold `out_accept_i` = 0 for 10 cycles with words pending → `out_data_o` and `out_chan_o` unchanged, no FIFO count decrements.
- Mid-operation reset: pulse `main_rst_an_i` low with 3 words buffered → all outputs return to reset values asynchronously, and no stale word appears after release.
